// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the divider: default operand width and the
// 2-bit divider FSM state encoding.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left by one, trial-subtract
// the divisor, keep the difference and emit a 1 quotient bit when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dsr});
  // When the subtraction fits the true difference is below dsr, so the
  // low WIDTH bits of a modular subtract are exact.
  assign diff    = shifted[WIDTH-1:0] - dsr;

  assign rem_next = fits ? diff : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider with pipeline stall and
// annul handling. Result is {remainder, quotient}, valid while ready_o=1.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o,
  output logic [1:0]           state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t          state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    quo_q;
  logic [WIDTH-1:0]    dsr_q;
  logic                neg_quo;
  logic                neg_rem;
  logic [2*WIDTH-1:0]  result_q;

  logic                go;
  logic [WIDTH-1:0]    mag1;
  logic [WIDTH-1:0]    mag2;
  logic [WIDTH-1:0]    rem_nx;
  logic [WIDTH-1:0]    quo_nx;
  logic [WIDTH-1:0]    quo_fin;
  logic [WIDTH-1:0]    rem_fin;

  assign go   = start_i & ~annul_i;
  assign mag1 = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dsr      (dsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Sign fix-up applied to the last step's output; negation wraps, so
  // most-negative / -1 yields the most-negative quotient without a trap.
  assign quo_fin = neg_quo ? -quo_nx : quo_nx;
  assign rem_fin = neg_rem ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= mag1;
            dsr_q   <= mag2;
            neg_quo <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem <= signed_i & opdata1_i[WIDTH-1];
          end
        end
        S_BYZERO: begin
          state    <= annul_i ? S_IDLE : S_END;
          result_q <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= S_END;
              result_q <= {rem_fin, quo_fin};
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state    <= S_IDLE;
            result_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (state == S_END);
  assign result_o = (state == S_END) ? result_q : '0;
  assign stall_o  = (state == S_BYZERO) || (state == S_ON) ||
                    ((state == S_IDLE) && go);
  assign state_o  = state;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; result is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  divide request from the execute stage (divE); held high by the pipeline until ready_o is seen.
REQ-005 signed_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-006 opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-007 opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-008 annul_i  input  1  cancel request (flushE / exception); aborts any operation in flight.
REQ-009 result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}; valid only while ready_o=1.
REQ-010 ready_o  output  1  result valid, write-enable for HI/LO.
REQ-011 stall_o  output  1  pipeline hold request while a divide is pending.

Function
REQ-012 The FSM SHALL have four states: IDLE, BYZERO, ON, END.
REQ-013 IDLE: if start_i=1 and annul_i=0, go to BYZERO when opdata2_i=0, else go to ON; latch operands, clear the iteration counter; otherwise stay.
REQ-014 BYZERO: go to END with result forced to all zeros.
REQ-015 ON: perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to END; the counter SHALL NOT wrap past WIDTH.
REQ-016 END: ready_o=1, result_o held stable; return to IDLE when start_i=0, else stay in END.
REQ-017 Latency: ready_o SHALL first be high after exactly WIDTH+1 rising edges from the edge that samples start_i (normal) and after 2 edges (divide-by-zero).
REQ-018 Signed mode: divide operand magnitudes; quotient negated if the operand signs differ; remainder takes the dividend's sign; all arithmetic is modulo 2^WIDTH.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-020 stall_o SHALL be 1 in BYZERO and ON, and in IDLE when start_i=1 and annul_i=0; 0 in END and otherwise.
REQ-021 annul_i=1 in BYZERO or ON SHALL return the FSM to IDLE on the next edge with ready_o kept 0; annul_i in END SHALL return to IDLE and drop ready_o on the next edge; annul_i has priority over start_i.
REQ-022 result_o SHALL be zero in every state other than END.
REQ-023 A new start_i is accepted only in IDLE; start_i level in ON/BYZERO is ignored.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, counter 0, and internal registers 0, and SHALL set result_o=0, ready_o=0, stall_o=0 (combinational from IDLE with start_i=0), including mid-operation.
REQ-025 After rst deasserts, the first divide SHALL be accepted on the first edge with start_i=1.

Structure
REQ-026 State encoding (2-bit IDLE/BYZERO/ON/END) and WIDTH default SHALL live in the shared CPU definitions package.
REQ-027 One combinational sub-module div_step SHALL implement a single restoring step (shift, trial subtract, quotient bit); div_unit owns the FSM, counter, sign fix-up, and registers.

Verification
REQ-028 Unsigned 100/7, start at edge 0 -> ready_o=1 after edge 33, result_o=64'h00000002_0000000E, stall_o=0 that cycle.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD.
REQ-030 Divide-by-zero 5/0 -> BYZERO then END, ready_o=1 after edge 2, result_o=0.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000.
REQ-032 Start 100/7, annul_i=1 at cycle 10 -> IDLE next edge, ready_o never asserted, stall_o=0; then 9/3 completes with result_o=64'h00000000_00000003.
REQ-033 Start divide, rst=0 asynchronously at cycle 15 -> outputs 0 immediately, IDLE after release, next divide correct.
